// File: rtl/rename_pkg.sv
// rename_pkg: shared widths, instruction field positions and register typedefs
// for the register rename unit and its free list.
package rename_pkg;
    localparam int ARCH_REG_ADDR_WIDTH = 5;
    localparam int REG_FILE_ADDR_WIDTH = 7;
    localparam int NUM_ARCH_REGS       = 2 ** ARCH_REG_ADDR_WIDTH;
    localparam int FREE_LIST_DEPTH     = 2 ** REG_FILE_ADDR_WIDTH - 2 ** ARCH_REG_ADDR_WIDTH;
    localparam int RD_LSB              = 7;
    localparam int RS1_LSB             = 15;
    localparam int RS2_LSB             = 20;
    typedef logic [REG_FILE_ADDR_WIDTH-1:0] phys_reg_t;
    typedef logic [ARCH_REG_ADDR_WIDTH-1:0] arch_reg_t;
endpackage

// File: rtl/phys_free_list.sv
// phys_free_list: circular FIFO of free physical registers, preloaded with the
// registers above the architectural range.
// Ports: clock/reset (sync, active-high); pop takes head_reg; push0 then push1
// are written at consecutive tail slots in the same cycle; count is the
// registered occupancy; overflow is sticky once any push is dropped.
module phys_free_list
    import rename_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      pop,
    input  logic      push0_valid,
    input  phys_reg_t push0_reg,
    input  logic      push1_valid,
    input  phys_reg_t push1_reg,
    output phys_reg_t head_reg,
    output phys_reg_t count,
    output logic      overflow
);
    typedef logic [REG_FILE_ADDR_WIDTH:0] wide_t;
    localparam phys_reg_t LAST    = phys_reg_t'(FREE_LIST_DEPTH - 1);
    localparam wide_t     DEPTH_W = wide_t'(FREE_LIST_DEPTH);

    phys_reg_t mem_q [FREE_LIST_DEPTH];
    phys_reg_t mem_d [FREE_LIST_DEPTH];
    phys_reg_t head_q, head_d, tail_q, tail_d, count_q, count_d, tail1;
    logic      overflow_q, overflow_d, pop_ok, acc0, acc1;
    wide_t     room;

    function automatic phys_reg_t wrap_inc(input phys_reg_t p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign head_reg = mem_q[head_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        pop_ok = pop && count_q != '0;
        // A pop in the same cycle frees a slot, so a full list can still absorb one push.
        room = DEPTH_W - {1'b0, count_q} + wide_t'(pop_ok);
        acc0 = push0_valid && room != '0;
        acc1 = push1_valid && room > wide_t'(acc0);
        tail1 = wrap_inc(tail_q);
        mem_d = mem_q;
        if (acc0) mem_d[tail_q] = push0_reg;
        if (acc1) mem_d[acc0 ? tail1 : tail_q] = push1_reg;
        tail_d = (acc0 && acc1) ? wrap_inc(tail1) : (acc0 || acc1) ? tail1 : tail_q;
        head_d = pop_ok ? wrap_inc(head_q) : head_q;
        count_d = count_q + phys_reg_t'(acc0) + phys_reg_t'(acc1) - phys_reg_t'(pop_ok);
        overflow_d = overflow_q || (push0_valid && !acc0) || (push1_valid && !acc1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++) mem_q[i] <= phys_reg_t'(NUM_ARCH_REGS + i);
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= phys_reg_t'(FREE_LIST_DEPTH);
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: rtl/register_rename_unit.sv
// register_rename_unit: RAT plus free list; renames sources/destination of the
// incoming instruction, frees old mappings on retire, undoes mappings on rollback.
// Ports: clock/reset (sync, active-high); rename_* in, src/dest/old_dest_phys
// and rename_ready out; retire_* and rollback_* from the ROB; free_count and
// sticky free_list_overflow status.
module register_rename_unit
    import rename_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        rename_valid,
    input  logic [31:0] rename_instr,
    input  logic        rename_has_dest,
    output logic        rename_ready,
    output phys_reg_t   src1_phys,
    output phys_reg_t   src2_phys,
    output phys_reg_t   dest_phys,
    output phys_reg_t   old_dest_phys,
    input  logic        retire_valid,
    input  phys_reg_t   retire_old_dest,
    input  logic        rollback_valid,
    input  logic [31:0] rollback_instr,
    input  phys_reg_t   rollback_old_dest,
    output phys_reg_t   free_count,
    output logic        free_list_overflow
);
    phys_reg_t rat_q [NUM_ARCH_REGS];
    phys_reg_t rat_d [NUM_ARCH_REGS];
    arch_reg_t rd, rs1, rs2, rb_rd;
    phys_reg_t head_reg;
    logic      alloc, fire_alloc, rb_act, unused;

    assign rd    = rename_instr[RD_LSB +: ARCH_REG_ADDR_WIDTH];
    assign rs1   = rename_instr[RS1_LSB +: ARCH_REG_ADDR_WIDTH];
    assign rs2   = rename_instr[RS2_LSB +: ARCH_REG_ADDR_WIDTH];
    assign rb_rd = rollback_instr[RD_LSB +: ARCH_REG_ADDR_WIDTH];
    assign unused = ^{rename_instr[31:25], rename_instr[14:12], rename_instr[6:0],
                      rollback_instr[31:12], rollback_instr[6:0]};

    assign alloc         = rename_has_dest && rd != '0;
    assign rename_ready  = !rollback_valid && (!alloc || free_count != '0);
    assign fire_alloc    = rename_valid && rename_ready && alloc;
    // Sources read the pre-update RAT, so rs==rd sees the previous producer.
    assign src1_phys     = rat_q[rs1];
    assign src2_phys     = rat_q[rs2];
    assign dest_phys     = alloc ? head_reg : '0;
    assign old_dest_phys = alloc ? rat_q[rd] : '0;
    // When the RAT already holds old_dest the entry was never applied, so nothing to undo.
    assign rb_act = rollback_valid && rb_rd != '0 && rat_q[rb_rd] != rollback_old_dest;

    always_comb begin
        rat_d = rat_q;
        if (fire_alloc) rat_d[rd] = head_reg;
        if (rb_act) rat_d[rb_rd] = rollback_old_dest;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) rat_q[i] <= phys_reg_t'(i);
        end else begin
            rat_q <= rat_d;
        end
    end

    phys_free_list u_free_list (
        .clock       (clock),
        .reset       (reset),
        .pop         (fire_alloc),
        .push0_valid (rb_act),
        .push0_reg   (rat_q[rb_rd]),
        .push1_valid (retire_valid && retire_old_dest != '0),
        .push1_reg   (retire_old_dest),
        .head_reg    (head_reg),
        .count       (free_count),
        .overflow    (free_list_overflow)
    );
endmodule

// File: tb/tb_register_rename_unit.sv
// tb_register_rename_unit: directed self-checking bench for register_rename_unit.
module tb_register_rename_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rename_valid = 1'b0;
    logic [31:0] rename_instr = '0;
    logic        rename_has_dest = 1'b0;
    logic        rename_ready;
    logic [6:0]  src1_phys, src2_phys, dest_phys, old_dest_phys;
    logic        retire_valid = 1'b0;
    logic [6:0]  retire_old_dest = '0;
    logic        rollback_valid = 1'b0;
    logic [31:0] rollback_instr = '0;
    logic [6:0]  rollback_old_dest = '0;
    logic [6:0]  free_count;
    logic        free_list_overflow;
    int checks = 0;
    int errors = 0;

    register_rename_unit dut (
        .clock              (clock),
        .reset              (reset),
        .rename_valid       (rename_valid),
        .rename_instr       (rename_instr),
        .rename_has_dest    (rename_has_dest),
        .rename_ready       (rename_ready),
        .src1_phys          (src1_phys),
        .src2_phys          (src2_phys),
        .dest_phys          (dest_phys),
        .old_dest_phys      (old_dest_phys),
        .retire_valid       (retire_valid),
        .retire_old_dest    (retire_old_dest),
        .rollback_valid     (rollback_valid),
        .rollback_instr     (rollback_instr),
        .rollback_old_dest  (rollback_old_dest),
        .free_count         (free_count),
        .free_list_overflow (free_list_overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        logic [31:0] v;
        v = '0;
        v[11:7]  = 5'(rd);
        v[19:15] = 5'(rs1);
        v[24:20] = 5'(rs2);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic ren(input logic v, input logic hd, input int rd, input int rs1, input int rs2);
        rename_valid = v;
        rename_has_dest = hd;
        rename_instr = mk(rd, rs1, rs2);
    endtask

    task automatic idle();
        ren(0, 0, 0, 0, 0);
        retire_valid = 0;
        retire_old_dest = '0;
        rollback_valid = 0;
        rollback_instr = '0;
        rollback_old_dest = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    initial begin
        // Basic lookup after reset
        do_reset();
        check("rst_count", free_count, 96);
        check("rst_ready", rename_ready, 1);
        check("rst_ovf", free_list_overflow, 0);
        ren(1, 0, 3, 5, 9);
        #1;
        check("nodest_src1", src1_phys, 5);
        check("nodest_src2", src2_phys, 9);
        check("nodest_dest", dest_phys, 0);
        check("nodest_old", old_dest_phys, 0);
        check("nodest_ready", rename_ready, 1);
        cyc();
        check("nodest_count", free_count, 96);
        // Back-to-back rename of rd=3
        ren(1, 1, 3, 0, 0);
        #1;
        check("r3a_dest", dest_phys, 32);
        check("r3a_old", old_dest_phys, 3);
        cyc();
        ren(1, 1, 3, 3, 0);
        #1;
        check("r3b_src1", src1_phys, 32);
        check("r3b_dest", dest_phys, 33);
        check("r3b_old", old_dest_phys, 32);
        cyc();
        check("r3_count", free_count, 94);
        // x0 destination is never renamed
        ren(1, 1, 0, 0, 0);
        #1;
        check("x0_dest", dest_phys, 0);
        check("x0_old", old_dest_phys, 0);
        cyc();
        check("x0_count", free_count, 94);

        // Exhaust the free list
        do_reset();
        for (int i = 0; i < 96; i++) begin
            ren(1, 1, 1, 0, 0);
            #1;
            check("drain_dest", dest_phys, 32 + i);
            cyc();
        end
        #1;
        check("empty_count", free_count, 0);
        check("empty_ready", rename_ready, 0);
        ren(1, 0, 1, 0, 0);
        #1;
        check("empty_nodest_ready", rename_ready, 1);
        ren(1, 1, 1, 0, 0);
        retire_valid = 1;
        retire_old_dest = 7'd3;
        #1;
        check("empty_retire_ready", rename_ready, 0);
        cyc();
        retire_valid = 0;
        #1;
        check("refill_ready", rename_ready, 1);
        check("refill_dest", dest_phys, 3);
        check("refill_count", free_count, 1);
        cyc();
        check("refill_pop_count", free_count, 0);

        // Rollback walk
        do_reset();
        ren(1, 1, 7, 0, 0);
        #1;
        check("rb_a_dest", dest_phys, 32);
        cyc();
        #1;
        check("rb_b_dest", dest_phys, 33);
        check("rb_b_old", old_dest_phys, 32);
        cyc();
        ren(1, 1, 5, 0, 0);
        rollback_valid = 1;
        rollback_instr = mk(7, 0, 0);
        rollback_old_dest = 7'd32;
        #1;
        check("rb1_ready", rename_ready, 0);
        cyc();
        check("rb1_count", free_count, 95);
        rollback_old_dest = 7'd7;
        #1;
        check("rb2_ready", rename_ready, 0);
        cyc();
        check("rb2_count", free_count, 96);
        cyc();
        check("rb_noop_count", free_count, 96);
        check("rb_noop_ovf", free_list_overflow, 0);
        idle();
        ren(1, 0, 0, 7, 0);
        #1;
        check("rb_rat7", src1_phys, 7);
        ren(1, 1, 1, 0, 0);
        #1;
        check("rb_next_dest", dest_phys, 34);

        // Rollback push lands before retire push
        do_reset();
        ren(1, 1, 7, 0, 0);
        cyc();
        ren(1, 1, 8, 0, 0);
        cyc();
        idle();
        rollback_valid = 1;
        rollback_instr = mk(8, 0, 0);
        rollback_old_dest = 7'd8;
        retire_valid = 1;
        retire_old_dest = 7'd40;
        cyc();
        idle();
        check("dual_count", free_count, 96);
        ren(0, 0, 0, 8, 0);
        #1;
        check("dual_rat8", src1_phys, 8);
        for (int i = 0; i < 94; i++) begin
            ren(1, 1, 1, 0, 0);
            cyc();
        end
        #1;
        check("order_first", dest_phys, 33);
        cyc();
        check("order_second", dest_phys, 40);
        cyc();
        check("order_count", free_count, 0);

        // Overflow on a full list is dropped and sticky
        do_reset();
        retire_valid = 1;
        retire_old_dest = 7'd40;
        cyc();
        check("ovf_set", free_list_overflow, 1);
        check("ovf_count", free_count, 96);
        idle();
        cyc();
        check("ovf_sticky", free_list_overflow, 1);

        // Reset wins over simultaneous rollback and retire
        ren(1, 1, 7, 0, 0);
        cyc();
        check("pre_rst_count", free_count, 95);
        idle();
        rollback_valid = 1;
        rollback_instr = mk(7, 0, 0);
        rollback_old_dest = 7'd7;
        retire_valid = 1;
        retire_old_dest = 7'd40;
        reset = 1;
        cyc();
        reset = 0;
        idle();
        #1;
        check("mid_rst_count", free_count, 96);
        check("mid_rst_ovf", free_list_overflow, 0);
        check("mid_rst_ready", rename_ready, 1);
        ren(1, 1, 1, 7, 0);
        #1;
        check("mid_rst_rat7", src1_phys, 7);
        check("mid_rst_dest", dest_phys, 32);
        check("mid_rst_old", old_dest_phys, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
